// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: forwards 32-bit message words as 16-word blocks,
// appending the 0x80 marker, zero fill and the 64-bit big-endian bit length.
module sha256_msg_padder #(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic [1:0]  s_last_bytes,
  output logic        blk_valid,
  output logic [31:0] blk_data,
  output logic        blk_first,
  input  logic        core_done,
  output logic        msg_done
);

  typedef enum logic [2:0] {IDLE, DATA, PAD, WAIT_D, WAIT_P, WAIT_F} state_t;

  state_t           state_q;
  logic [4:0]       widx_q;
  logic [LEN_W-1:0] blen_q;
  logic             pend_q;
  logic             wrap_q;
  logic             s_ready_q;
  logic             blk_valid_q;
  logic             blk_first_q;
  logic             msg_done_q;
  logic [31:0]      blk_data_q;

  logic             xfer;
  logic [5:0]       inc_d;
  logic [LEN_W-1:0] blen_d;
  logic [4:0]       widx_d;
  logic [63:0]      len64;
  logic [31:0]      word_d;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Input-side datapath: length increment and the marker-merged last word.
  always_comb begin
    xfer   = s_valid & s_ready_q;
    inc_d  = 6'd32;
    if (s_last && s_last_bytes != 2'd0) inc_d = 6'({s_last_bytes, 3'b000});
    blen_d = ((state_q == IDLE) ? '0 : blen_q) + LEN_W'(inc_d);
    widx_d = widx_q + 5'd1;
    len64  = 64'(blen_q);
    word_d = s_data;
    if (s_last) begin
      case (s_last_bytes)
        2'd1:    word_d = {16'h0000, 8'h80, s_data[7:0]};
        2'd2:    word_d = {8'h00, 8'h80, s_data[15:0]};
        2'd3:    word_d = {8'h80, s_data[23:0]};
        default: word_d = s_data;
      endcase
    end
  end

  // Main FSM; wrap_q marks a block whose marker landed too late for the length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      widx_q      <= '0;
      blen_q      <= '0;
      pend_q      <= 1'b0;
      wrap_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      blk_valid_q <= 1'b0;
      blk_first_q <= 1'b0;
      msg_done_q  <= 1'b0;
      blk_data_q  <= '0;
    end else begin
      blk_valid_q <= 1'b0;
      blk_first_q <= 1'b0;
      msg_done_q  <= 1'b0;
      case (state_q)
        IDLE, DATA: begin
          if (xfer) begin
            blk_valid_q <= 1'b1;
            blk_data_q  <= word_d;
            blk_first_q <= (state_q == IDLE);
            widx_q      <= widx_d;
            blen_q      <= blen_d;
            if (s_last) begin
              pend_q    <= (s_last_bytes == 2'd0);
              s_ready_q <= 1'b0;
              if (s_last_bytes != 2'd0 && widx_q >= 5'd14) wrap_q <= 1'b1;
              state_q   <= (widx_q == 5'd15) ? WAIT_P : PAD;
            end else if (widx_q == 5'd15) begin
              s_ready_q <= 1'b0;
              state_q   <= WAIT_D;
            end else begin
              state_q   <= DATA;
            end
          end else if (state_q == IDLE) begin
            s_ready_q <= 1'b1;
          end
        end
        PAD: begin
          blk_valid_q <= 1'b1;
          widx_q      <= widx_d;
          if (pend_q) begin
            blk_data_q <= 32'h0000_0080;
            pend_q     <= 1'b0;
            if (widx_q >= 5'd14) wrap_q <= 1'b1;
          end else if (!wrap_q && widx_q == 5'd14) begin
            blk_data_q <= bswap(len64[63:32]);
          end else if (!wrap_q && widx_q == 5'd15) begin
            blk_data_q <= bswap(len64[31:0]);
          end else begin
            blk_data_q <= '0;
          end
          if (widx_q == 5'd15) state_q <= (wrap_q || pend_q) ? WAIT_P : WAIT_F;
        end
        WAIT_D: begin
          if (core_done) begin
            widx_q    <= '0;
            s_ready_q <= 1'b1;
            state_q   <= DATA;
          end
        end
        WAIT_P: begin
          if (core_done) begin
            widx_q  <= '0;
            wrap_q  <= 1'b0;
            state_q <= PAD;
          end
        end
        WAIT_F: begin
          if (core_done) begin
            widx_q     <= '0;
            wrap_q     <= 1'b0;
            msg_done_q <= 1'b1;
            s_ready_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign blk_valid = blk_valid_q;
  assign blk_data  = blk_data_q;
  assign blk_first = blk_first_q;
  assign msg_done  = msg_done_q;

endmodule
